// File: rtl/ro_pkg.sv
// Shared constants and helpers for the ring-oscillator entropy sampler.
package ro_pkg;

  localparam int RO_DEFAULT_DIV         = 16;
  localparam int RO_DEFAULT_OUT_WIDTH   = 8;
  localparam int RO_DEFAULT_STUCK_LIMIT = 32;

  // Smallest n with (1 << n) >= value; elaboration-time use only.
  function automatic int ro_clog2(input int value);
    int n;
    n = 0;
    while ((1 << n) < value) n++;
    return n;
  endfunction

endpackage

// File: rtl/ro_vn_debias.sv
// Von Neumann debiaser: pairs raw bits (a, b) and emits a when a != b.
// Pairs never overlap; clear drops a pending half-pair.
module ro_vn_debias
  import ro_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic in_bit,
  input  logic in_stb,
  output logic out_bit,
  output logic out_stb
);

  logic half_vld;
  logic half_bit;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      half_vld <= 1'b0;
      half_bit <= 1'b0;
    end else if (in_stb) begin
      half_vld <= !half_vld;
      if (!half_vld) half_bit <= in_bit;
    end
  end

  assign out_stb = in_stb && half_vld && (half_bit != in_bit);
  assign out_bit = half_bit;

endmodule

// File: rtl/ro_entropy_sampler.sv
// Ring-oscillator sampler: sync, divide, health-check, optional Von Neumann
// debias (define RO_SAMPLER_VN_EN), pack into words, valid/ready output.
module ro_entropy_sampler
  import ro_pkg::*;
#(
  parameter int DIV         = RO_DEFAULT_DIV,
  parameter int OUT_WIDTH   = RO_DEFAULT_OUT_WIDTH,
  parameter int STUCK_LIMIT = RO_DEFAULT_STUCK_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ro_in,
  input  logic                 enable,
  output logic [OUT_WIDTH-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overflow,
  output logic                 stuck
);

  localparam int CNT_W = ro_clog2(DIV);
  localparam int RUN_W = ro_clog2(STUCK_LIMIT + 1);
  localparam int BC_W  = ro_clog2(OUT_WIDTH + 1);

  logic                 sync_p0;
  logic                 sync_p1;
  logic [CNT_W-1:0]     div_cnt;
  logic                 stb_p1;
  logic                 raw_p1;
  logic                 raw_prev;
  logic [RUN_W-1:0]     run_cnt;
  logic                 emit_bit;
  logic                 emit_stb;
  logic [OUT_WIDTH-1:0] shreg;
  logic [OUT_WIDTH-1:0] word_nxt;
  logic [BC_W-1:0]      bit_cnt;
  logic                 word_done;
  logic                 word_load;
  logic                 word_drop;

  function automatic logic [RUN_W-1:0] run_sat_inc(input logic [RUN_W-1:0] v);
    return (v == RUN_W'(STUCK_LIMIT)) ? v : v + RUN_W'(1);
  endfunction

  // Stage p0/p1: two-flop synchroniser; sync_p1 is the sample source
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= ro_in;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) div_cnt <= '0;
    else if (div_cnt == CNT_W'(DIV - 1)) div_cnt <= '0;
    else div_cnt <= div_cnt + CNT_W'(1);
  end

  assign stb_p1 = enable && (div_cnt == CNT_W'(DIV - 1));
  assign raw_p1 = sync_p1;

  // Health check: run length of identical raw samples, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt  <= '0;
      raw_prev <= 1'b0;
    end else if (!enable) begin
      run_cnt <= '0;
    end else if (stb_p1) begin
      raw_prev <= raw_p1;
      run_cnt  <= (raw_p1 != raw_prev) ? RUN_W'(1) : run_sat_inc(run_cnt);
    end
  end

  assign stuck = (run_cnt == RUN_W'(STUCK_LIMIT));

`ifdef RO_SAMPLER_VN_EN
  logic vn_clear;
  assign vn_clear = !enable;

  ro_vn_debias u_vn_debias (
    .clk     (clk),
    .rst     (rst),
    .clear   (vn_clear),
    .in_bit  (raw_p1),
    .in_stb  (stb_p1),
    .out_bit (emit_bit),
    .out_stb (emit_stb)
  );
`else
  assign emit_bit = raw_p1;
  assign emit_stb = stb_p1;
`endif

  // Packer: oldest bit ends up at the MSB
  assign word_nxt  = (shreg << 1) | OUT_WIDTH'(emit_bit);
  assign word_done = emit_stb && (bit_cnt == BC_W'(OUT_WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (emit_stb) begin
      shreg   <= word_nxt;
      bit_cnt <= word_done ? '0 : bit_cnt + BC_W'(1);
    end
  end

  // Output register: words completed while stuck are discarded silently
  assign word_load = word_done && !stuck && (!valid || ready);
  assign word_drop = word_done && !stuck && valid && !ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (word_load) begin
        data  <= word_nxt;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (word_drop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ro_entropy_sampler.sv
// Self-checking bench for ro_entropy_sampler (either RO_SAMPLER_VN_EN build):
// directed scenarios plus random stimulus against a queue-based model.
module tb_ro_entropy_sampler;

  localparam int DIV   = 4;
  localparam int OUT_W = 8;
  localparam int STUCK = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ro_in = 1'b0;
  logic             enable = 1'b0;
  logic             ready = 1'b0;
  logic [OUT_W-1:0] data;
  logic             valid;
  logic             overflow;
  logic             stuck;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  ro_entropy_sampler #(.DIV(DIV), .OUT_WIDTH(OUT_W), .STUCK_LIMIT(STUCK)) dut (
    .clk      (clk),
    .rst      (rst),
    .ro_in    (ro_in),
    .enable   (enable),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .overflow (overflow),
    .stuck    (stuck)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic             m_d0 = 1'b0, m_d1 = 1'b0;
  int               m_en_run = 0;
  int               m_run = 0;
  logic             m_prev = 1'b0;
  logic             m_pend[$];
  logic             m_bits[$];
  logic             m_valid = 1'b0;
  logic [OUT_W-1:0] m_data = '0;
  logic             m_ovf = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(posedge clk) begin : model
    logic s, r, a, emit, ebit, done, stuck_before;
    logic [OUT_W-1:0] w;
    s = m_d1;
    done = 1'b0;
    w = '0;
    if (rst) begin
      m_d0 = 1'b0; m_d1 = 1'b0; m_en_run = 0; m_run = 0; m_prev = 1'b0;
      m_pend.delete(); m_bits.delete();
      m_valid = 1'b0; m_data = '0; m_ovf = 1'b0;
    end else begin
      m_d1 = m_d0;
      m_d0 = ro_in;
      stuck_before = (m_run == STUCK);
      if (!enable) begin
        m_en_run = 0; m_run = 0;
        m_pend.delete(); m_bits.delete();
      end else begin
        if (m_en_run % DIV == DIV - 1) begin
          r = s;
          m_run = (r != m_prev) ? 1 : ((m_run + 1 > STUCK) ? STUCK : m_run + 1);
          m_prev = r;
          emit = 1'b0; ebit = 1'b0;
`ifdef RO_SAMPLER_VN_EN
          if (m_pend.size() == 0) m_pend.push_back(r);
          else begin
            a = m_pend.pop_front();
            if (a != r) begin emit = 1'b1; ebit = a; end
          end
`else
          emit = 1'b1; ebit = r;
`endif
          if (emit) begin
            m_bits.push_back(ebit);
            if (m_bits.size() == OUT_W) begin
              foreach (m_bits[i]) w = {w[OUT_W-2:0], m_bits[i]};
              m_bits.delete();
              done = 1'b1;
            end
          end
        end
        m_en_run++;
      end
      if (done && !stuck_before) begin
        if (!m_valid || ready) begin m_data = w; m_valid = 1'b1; end
        else m_ovf = 1'b1;
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_data", 32'(data), 32'(m_data));
      check("cyc_valid", 32'(valid), 32'(m_valid));
      check("cyc_overflow", 32'(overflow), 32'(m_ovf));
      check("cyc_stuck", 32'(stuck), 32'(m_run == STUCK));
    end
  end

  // Holds ro_in for one strobe period; optionally raises ready in its last cycle.
  task automatic send_bit(input logic b, input bit rdy_last);
    ro_in = b;
    repeat (DIV - 1) @(negedge clk);
    if (rdy_last) ready = 1'b1;
    @(negedge clk);
    if (rdy_last) ready = 1'b0;
  endtask

  // Drives the first n bits of w (MSB first) as emitted packer bits.
  task automatic gen_bits(input logic [OUT_W-1:0] w, input int n, input bit rdy_at_end);
    for (int i = 0; i < n; i++) begin
      logic b;
      bit last;
      b = w[OUT_W-1-i];
      last = rdy_at_end && (i == n - 1);
`ifdef RO_SAMPLER_VN_EN
      send_bit(b, 1'b0);
      send_bit(!b, last);
`else
      send_bit(b, last);
`endif
    end
  endtask

  task automatic restart();
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1; enable = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    chk_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ro_in = ~ro_in;
      @(negedge clk);
      check("rst_data", 32'(data), 32'h0);
      check("rst_valid", 32'(valid), 32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);
      check("rst_stuck", 32'(stuck), 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(valid), 32'h0);
    check("post_rst_data", 32'(data), 32'h0);

`ifdef RO_SAMPLER_VN_EN
    restart();
    for (int i = 0; i < 8; i++) begin send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); end
    check("vn01_valid", 32'(valid), 32'h1);
    check("vn01_data", 32'(data), 32'h00);
    check("vn01_model", 32'(m_data), 32'h00);
    drain();
    restart();
    for (int i = 0; i < 8; i++) begin send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); end
    check("vn10_data", 32'(data), 32'hFF);
    check("vn10_model", 32'(m_data), 32'hFF);
    drain();
    restart();
    for (int i = 0; i < 32; i++) begin send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); end
    check("vn11_novalid", 32'(valid), 32'h0);
    pulse_rst();
`endif

    restart();
    gen_bits(8'hA5, 8, 1'b0);
    check("a5_valid", 32'(valid), 32'h1);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_model", 32'(m_data), 32'hA5);
    drain();
    check("a5_drained", 32'(valid), 32'h0);

    pulse_rst();
    restart();
    gen_bits(8'h3C, 8, 1'b0);
    gen_bits(8'hC3, 8, 1'b0);
    check("bp_data", 32'(data), 32'h3C);
    check("bp_overflow", 32'(overflow), 32'h1);
    check("bp_model_ovf", 32'(m_ovf), 32'h1);
    drain();
    check("bp_valid_after", 32'(valid), 32'h0);
    check("bp_ovf_sticky", 32'(overflow), 32'h1);

    pulse_rst();
    restart();
    gen_bits(8'h96, 8, 1'b0);
    check("sim_first", 32'(data), 32'h96);
    gen_bits(8'h69, 8, 1'b1);
    check("sim_data", 32'(data), 32'h69);
    check("sim_valid", 32'(valid), 32'h1);
    check("sim_overflow", 32'(overflow), 32'h0);
    drain();

    pulse_rst();
    restart();
    for (int i = 0; i < STUCK - 1; i++) send_bit(1'b1, 1'b0);
    check("stuck_before", 32'(stuck), 32'h0);
    send_bit(1'b1, 1'b0);
    check("stuck_set", 32'(stuck), 32'h1);
    check("stuck_model", 32'(m_run), 32'(STUCK));
    send_bit(1'b0, 1'b0);
    check("stuck_clear", 32'(stuck), 32'h0);

    pulse_rst();
    restart();
    gen_bits(8'hB4, 5, 1'b0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("en_drop_novalid", 32'(valid), 32'h0);
    restart();
    gen_bits(8'h5A, 8, 1'b0);
    check("en_word_valid", 32'(valid), 32'h1);
    check("en_word_data", 32'(data), 32'h5A);
    check("en_word_ovf", 32'(overflow), 32'h0);
    drain();

    pulse_rst();
    enable = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      if (i < 3000) ro_in = $urandom_range(0, 1) ? 1'b1 : 1'b0;
      else if ($urandom_range(0, 47) == 0) ro_in = ~ro_in;
      ready = ($urandom_range(0, 2) != 0);
      if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
      else if (enable && $urandom_range(0, 299) == 0) enable = 1'b0;
      rst = ($urandom_range(0, 699) == 0);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
